// File: rtl/video_timing_gen_param.sv
// rtl/video_timing_gen_param.sv - parameterised raster timing generator with pause and resync
module video_timing_gen_param #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 13
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pause,
    input  logic             resync,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_cnt_w_check
            $error("CNT_W too narrow for the configured line or frame total");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;
    logic             h_act;
    logic             v_act;
    logic             h_in_sync;
    logic             v_in_sync;

    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign h_act     = (h_cnt < H_ACT);
    assign v_act     = (v_cnt < V_ACT);
    assign h_in_sync = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign v_in_sync = (v_cnt >= V_SS) && (v_cnt < V_SE);

    // Outputs decode the counter position held before this edge, giving one clock of latency.
    always_ff @(posedge pclk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
        end else if (!enable) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
        end else begin
            if (resync) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (!pause) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end

            // A paused position is emitted once, after the pause lifts.
            if (pause) begin
                de          <= 1'b0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end else begin
                de          <= h_act && v_act;
                hsync       <= h_in_sync ? HS_POL : ~HS_POL;
                vsync       <= v_in_sync ? VS_POL : ~VS_POL;
                line_start  <= (h_cnt == '0) && v_act;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                if (h_act && v_act) begin
                    x <= h_cnt;
                    y <= v_cnt;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen_param.sv
// tb/tb_video_timing_gen_param.sv - scoreboard bench for video_timing_gen_param on a 16x8 raster
module tb_video_timing_gen_param;
    localparam int CW = 13;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst;
    logic enable;
    logic pause;
    logic resync;

    logic          hs_p, vs_p, de_p, ls_p, fs_p;
    logic [CW-1:0] x_p, y_p;
    logic          hs_n, vs_n, de_n, ls_n, fs_n;
    logic [CW-1:0] x_n, y_n;

    video_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
    ) u_dut (
        .pclk(pclk), .rst(rst), .enable(enable), .pause(pause), .resync(resync),
        .hsync(hs_p), .vsync(vs_p), .de(de_p), .x(x_p), .y(y_p),
        .line_start(ls_p), .frame_start(fs_p)
    );

    video_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) u_dut_n (
        .pclk(pclk), .rst(rst), .enable(enable), .pause(pause), .resync(resync),
        .hsync(hs_n), .vsync(vs_n), .de(de_n), .x(x_n), .y(y_n),
        .line_start(ls_n), .frame_start(fs_n)
    );

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          ls;
        logic          fs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } obs_t;

    obs_t sb[$];
    int   fs_times[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference: linear pixel index over the 16x8 raster, active-high sync polarity.
    int   m_p = 0;
    obs_t m_o = '0;

    task automatic model(input logic r, input logic en, input logic pa, input logic rs);
        int h;
        int v;
        h = m_p % 16;
        v = m_p / 16;
        if (r) begin
            m_o = '0;
            m_p = 0;
        end else if (!en) begin
            m_o.hs = 1'b0;
            m_o.vs = 1'b0;
            m_o.de = 1'b0;
            m_o.ls = 1'b0;
            m_o.fs = 1'b0;
            m_p    = 0;
        end else begin
            if (pa) begin
                m_o.de = 1'b0;
                m_o.ls = 1'b0;
                m_o.fs = 1'b0;
            end else begin
                m_o.de = (h < 8) && (v < 4);
                m_o.hs = (h >= 10) && (h < 13);
                m_o.vs = (v >= 5) && (v < 7);
                m_o.ls = (h == 0) && (v < 4);
                m_o.fs = (m_p == 0);
                if (m_o.de) begin
                    m_o.x = CW'(h);
                    m_o.y = CW'(v);
                end
            end
            if (rs) m_p = 0;
            else if (!pa) m_p = (m_p + 1) % 128;
        end
    endtask

    task automatic step(input logic r, input logic en, input logic pa, input logic rs);
        @(negedge pclk);
        rst    = r;
        enable = en;
        pause  = pa;
        resync = rs;
        model(r, en, pa, rs);
        @(posedge pclk);
        #1;
        sb.push_back(m_o);
        cyc++;
        if (fs_p) fs_times.push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge pclk);
            if (sb.size() > 0) begin
                obs_t e;
                obs_t a;
                obs_t an;
                e  = sb.pop_front();
                a  = {hs_p, vs_p, de_p, ls_p, fs_p, x_p, y_p};
                an = {~hs_n, ~vs_n, de_n, ls_n, fs_n, x_n, y_n};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL sb_pos cyc=%0d got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d expected hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                             cyc, a.hs, a.vs, a.de, a.ls, a.fs, a.x, a.y,
                             e.hs, e.vs, e.de, e.ls, e.fs, e.x, e.y);
                end
                checks++;
                if (an !== e) begin
                    failures++;
                    $display("FAIL sb_neg cyc=%0d got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d expected hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d (syncs inverted)",
                             cyc, an.hs, an.vs, an.de, an.ls, an.fs, an.x, an.y,
                             e.hs, e.vs, e.de, e.ls, e.fs, e.x, e.y);
                end
            end
        end
    end

    initial begin
        int n_de;
        int n_hs;
        int n_vs;
        int first_hs;
        int n_busy;

        rst    = 1'b1;
        enable = 1'b0;
        pause  = 1'b0;
        resync = 1'b0;

        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_de", de_p, 0);
        check("rst_hs_pos", hs_p, 0);
        check("rst_hs_neg", hs_n, 1);
        check("rst_vs_neg", vs_n, 1);
        check("rst_x", x_p, 0);

        // Free run, three frames
        fs_times.delete();
        n_de = 0; n_hs = 0; n_vs = 0; first_hs = -1;
        for (int i = 0; i < 384; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                check("rel_fs", fs_p, 1);
                check("rel_de", de_p, 1);
            end
            if (de_p) n_de++;
            if (hs_p) n_hs++;
            if (vs_p) n_vs++;
            if (hs_p && first_hs < 0) first_hs = i;
        end
        check("run_de_cycles", n_de, 96);
        check("run_hs_cycles", n_hs, 72);
        check("run_vs_cycles", n_vs, 96);
        check("run_hs_offset", first_hs, 10);
        check("run_fs_count", fs_times.size(), 3);
        if (fs_times.size() == 3) begin
            check("run_period_a", fs_times[1] - fs_times[0], 128);
            check("run_period_b", fs_times[2] - fs_times[1], 128);
        end

        // Pause 5 cycles at h=4, v=1
        fs_times.delete();
        run(20);
        n_de = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (de_p) n_de++;
        end
        check("pause_de_cycles", n_de, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_resume_x", x_p, 4);
        check("pause_resume_y", y_p, 1);
        check("pause_resume_de", de_p, 1);
        run(108);
        check("pause_fs_count", fs_times.size(), 2);
        if (fs_times.size() == 2) check("pause_period", fs_times[1] - fs_times[0], 133);

        // Resync at v=5
        run(79);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("resync_edge_vs", vs_p, 1);
        check("resync_edge_fs", fs_p, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("resync_fs", fs_p, 1);
        check("resync_x", x_p, 0);
        check("resync_y", y_p, 0);
        check("resync_de", de_p, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("resync_pause_de", de_p, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("resync_pause_fs", fs_p, 1);

        // Enable low mid-frame, with resync toggling while disabled
        run(40);
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, (i % 2) == 1);
            if (de_p || hs_p || vs_p || ls_p || fs_p) n_busy++;
        end
        check("disable_idle", n_busy, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reenable_fs", fs_p, 1);
        check("reenable_x", x_p, 0);

        // Reset during vsync
        run(84);
        check("pre_rst_vs", vs_p, 1);
        check("pre_rst_vs_neg", vs_n, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("vrst_hs_neg", hs_n, 1);
        check("vrst_vs_neg", vs_n, 1);
        check("vrst_de", de_p, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("vrst_rel_fs", fs_p, 1);
        check("vrst_rel_y", y_p, 0);

        // Wrap corner h=15, v=7
        run(126);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("corner_de", de_p, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_fs", fs_p, 1);
        check("wrap_ls", ls_p, 1);
        check("wrap_de", de_p, 1);
        check("wrap_x", x_p, 0);
        check("wrap_y", y_p, 0);

        @(negedge pclk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
